// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multi-cycle MIPS main FSM and its datapath.
// master = controller side, slave = datapath side.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic [1:0] aluop;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
           aluop, instr_done, illegal_op, state
  );

  modport slave (
    output opcode,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
           aluop, instr_done, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: Moore mux selects and
// write enables from the current state, aluop from the next state.
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RCOMP   = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDIEX  = 4'd11,
    S_ADDIWB  = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RST;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_RST:    w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (bus.opcode == OP_LW || bus.opcode == OP_SW) w_next = S_MEMADR;
        else if (bus.opcode == OP_RTYPE)                w_next = S_EXEC;
        else if (bus.opcode == OP_BEQ)                  w_next = S_BRANCH;
        else if (bus.opcode == OP_J)                    w_next = S_JUMP;
        else if (bus.opcode == OP_ADDI)                 w_next = S_ADDIEX;
        else                                            w_next = S_ILLEGAL;
      end
      // IR is held after FETCH, so opcode still selects load vs store here
      S_MEMADR: w_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = S_RCOMP;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    bus.pcwrite     = 1'b0;
    bus.pcwritecond = 1'b0;
    bus.iord        = 1'b0;
    bus.memread     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.irwrite     = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.regdst      = 1'b0;
    bus.regwrite    = 1'b0;
    bus.alusrca     = 1'b0;
    bus.alusrcb     = 2'b00;
    bus.pcsource    = 2'b00;
    bus.instr_done  = 1'b0;
    bus.illegal_op  = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.memread = 1'b1;
        bus.irwrite = 1'b1;
        bus.pcwrite = 1'b1;
        bus.alusrcb = 2'b01;
      end
      S_DECODE: bus.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
      end
      S_MEMWB: begin
        bus.regwrite   = 1'b1;
        bus.memtoreg   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEMWR: begin
        bus.memwrite   = 1'b1;
        bus.iord       = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_EXEC: bus.alusrca = 1'b1;
      S_RCOMP: begin
        bus.regwrite   = 1'b1;
        bus.regdst     = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca     = 1'b1;
        bus.pcwritecond = 1'b1;
        bus.pcsource    = 2'b01;
        bus.instr_done  = 1'b1;
      end
      S_JUMP: begin
        bus.pcwrite    = 1'b1;
        bus.pcsource   = 2'b10;
        bus.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_ILLEGAL: bus.illegal_op = 1'b1;
      default: ;
    endcase
  end

  // Downstream ALU-control registers aluop, so it is decoded one state early
  always_comb begin
    bus.aluop = 2'b00;
    case (w_next)
      S_EXEC:   bus.aluop = 2'b10;
      S_BRANCH: bus.aluop = 2'b01;
      default:  bus.aluop = 2'b00;
    endcase
  end

  assign bus.state = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class
// through its states and checks state plus the full control vector each cycle.
module tb_mips_multicycle_ctrl;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
  //  regwrite, alusrca, alusrcb[2], pcsource[2], aluop[2], instr_done, illegal_op}
  logic [17:0] obs;
  assign obs = {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread,
                bus.memwrite, bus.irwrite, bus.memtoreg, bus.regdst,
                bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsource,
                bus.aluop, bus.instr_done, bus.illegal_op};

  localparam logic [17:0] V_RST    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] V_FETCH  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] V_DECADD = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] V_DECSUB = 18'b0_0_0_0_0_0_0_0_0_0_11_00_01_0_0;
  localparam logic [17:0] V_DECFN  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_10_0_0;
  localparam logic [17:0] V_MEMADR = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] V_MEMRD  = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] V_MEMWB  = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] V_MEMWR  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] V_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_00_00_00_0_0;
  localparam logic [17:0] V_RCOMP  = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] V_BRANCH = 18'b0_1_0_0_0_0_0_0_0_1_00_01_00_1_0;
  localparam logic [17:0] V_JUMP   = 18'b1_0_0_0_0_0_0_0_0_0_00_10_00_1_0;
  localparam logic [17:0] V_ADDIWB = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [17:0] V_ILL    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

  task automatic chk(input string tag, input logic [3:0] es, input logic [17:0] ev);
    n_chk++;
    assert (bus.state === es) else begin
      n_fail++;
      $error("FAIL %s state: observed %0d expected %0d", tag, bus.state, es);
    end
    n_chk++;
    assert (obs === ev) else begin
      n_fail++;
      $error("FAIL %s ctrl: observed %b expected %b", tag, obs, ev);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.opcode = 6'b000000;

    repeat (3) begin
      nxt();
      chk("reset", 4'd0, V_RST);
    end
    rst_n = 1'b1;
    #1 chk("release", 4'd0, V_RST);
    nxt(); chk("fetch0", 4'd1, V_FETCH);

    bus.opcode = 6'b100011;
    nxt(); chk("lw_dec", 4'd2, V_DECADD);
    nxt(); chk("lw_adr", 4'd3, V_MEMADR);
    nxt(); chk("lw_rd",  4'd4, V_MEMRD);
    nxt(); chk("lw_wb",  4'd5, V_MEMWB);
    nxt(); chk("lw_fet", 4'd1, V_FETCH);

    bus.opcode = 6'b000000;
    nxt(); chk("r_dec",  4'd2, V_DECFN);
    nxt(); chk("r_exe",  4'd7, V_EXEC);
    nxt(); chk("r_cmp",  4'd8, V_RCOMP);
    nxt(); chk("r_fet",  4'd1, V_FETCH);

    bus.opcode = 6'b000100;
    nxt(); chk("beq_dec", 4'd2, V_DECSUB);
    nxt(); chk("beq_br",  4'd9, V_BRANCH);
    nxt(); chk("beq_fet", 4'd1, V_FETCH);

    bus.opcode = 6'b001000;
    nxt(); chk("addi_dec", 4'd2,  V_DECADD);
    nxt(); chk("addi_ex",  4'd11, V_MEMADR);
    nxt(); chk("addi_wb",  4'd12, V_ADDIWB);
    nxt(); chk("addi_fet", 4'd1,  V_FETCH);

    bus.opcode = 6'b000010;
    nxt(); chk("j_dec", 4'd2,  V_DECADD);
    nxt(); chk("j_jmp", 4'd10, V_JUMP);
    nxt(); chk("j_fet", 4'd1,  V_FETCH);

    bus.opcode = 6'b111111;
    nxt(); chk("ill_dec", 4'd2,  V_DECADD);
    nxt(); chk("ill_ill", 4'd13, V_ILL);
    nxt(); chk("ill_fet", 4'd1,  V_FETCH);

    bus.opcode = 6'b101011;
    nxt(); chk("sw_dec", 4'd2, V_DECADD);
    nxt(); chk("sw_adr", 4'd3, V_MEMADR);
    #2 rst_n = 1'b0;
    #1 chk("sw_async_rst", 4'd0, V_RST);
    nxt(); chk("sw_in_rst", 4'd0, V_RST);
    rst_n = 1'b1;
    nxt(); chk("sw_fet",  4'd1, V_FETCH);
    nxt(); chk("sw_dec2", 4'd2, V_DECADD);
    nxt(); chk("sw_adr2", 4'd3, V_MEMADR);
    nxt(); chk("sw_wr",   4'd6, V_MEMWR);
    nxt(); chk("sw_fet2", 4'd1, V_FETCH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM of the multi-cycle MIPS datapath; sits directly upstream of the ALU-control decoder and supplies its 2-bit aluop.
- Decodes the 6-bit opcode from the instruction register and steps each instruction through fetch/decode/execute/memory/writeback states.
- Drives every datapath mux select and write enable.
- The downstream ALU-control decoder registers aluctrl on posedge clk, so this block presents aluop one cycle early.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch equal
- OP_J, 6'b000010, jump
- OP_ADDI, 6'b001000, add immediate

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from instruction register
- pcwrite  out  1  unconditional PC write
- pcwritecond  out  1  PC write if ALU zero
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- memtoreg  out  1  register write data: 0=ALUOut, 1=MDR
- regdst  out  1  destination register: 0=rt, 1=rd
- regwrite  out  1  register file write
- alusrca  out  1  ALU A: 0=PC, 1=reg A
- alusrcb  out  2  ALU B: 00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- pcsource  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- aluop  out  2  to ALU-control decoder: 00=add, 01=sub, 10=use funct
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal_op  out  1  one-cycle pulse for an unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- State register: 4 bits. rst_n low forces RST asynchronously; all other transitions occur on posedge clk.
- Encoding: RST=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RCOMP=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12, ILLEGAL=13. Codes 14 and 15 are unreachable and return to FETCH.
- Transitions:
  - RST->FETCH unconditionally.
  - FETCH->DECODE.
  - DECODE: LW/SW->MEMADR; RTYPE->EXEC; BEQ->BRANCH; J->JUMP; ADDI->ADDIEX; any other opcode->ILLEGAL.
  - MEMADR: LW->MEMRD; SW->MEMWR (opcode is stable because the IR is not rewritten).
  - MEMRD->MEMWB; EXEC->RCOMP; ADDIEX->ADDIWB.
  - MEMWB, MEMWR, RCOMP, BRANCH, JUMP, ADDIWB, ILLEGAL -> FETCH.
- Moore outputs decode combinationally from the current state. Any output not listed for a state is 0.
  - RST: all 0.
  - FETCH: memread, irwrite, pcwrite=1; alusrcb=01; pcsource=00.
  - DECODE: alusrcb=11.
  - MEMADR, ADDIEX: alusrca=1, alusrcb=10.
  - MEMRD: memread=1, iord=1.
  - MEMWB: regwrite=1, memtoreg=1.
  - MEMWR: memwrite=1, iord=1.
  - EXEC: alusrca=1, alusrcb=00.
  - RCOMP: regwrite=1, regdst=1.
  - BRANCH: alusrca=1, alusrcb=00, pcwritecond=1, pcsource=01.
  - JUMP: pcwrite=1, pcsource=10.
  - ADDIWB: regwrite=1.
- instr_done=1 in MEMWB, MEMWR, RCOMP, BRANCH, JUMP and ADDIWB. illegal_op=1 in ILLEGAL only.
- aluop is a combinational function of next_state, not the current state: EXEC->10, BRANCH->01, every other state->00. The downstream decoder samples aluop on the edge entering state S, so aluctrl is valid throughout S.
- Reset values: state=RST, every output 0, aluop=00 (next_state=FETCH).
- Reset mid-instruction: asynchronously returns to RST and every write enable drops immediately. The instruction restarts from FETCH after release.
- Instruction latency in cycles, FETCH through final state: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 3.

Test Plan:
- Hold rst_n=0 for 3 cycles, then release -> all outputs 0 and state=0 during reset; state=0, then 1 on the next edge with memread=irwrite=pcwrite=1.
- opcode=100011 (LW) -> states 1,2,3,4,5; regwrite=memtoreg=1 and instr_done=1 in state 5; back to 1.
- opcode=000000 (R-type) -> aluop=10 in the DECODE cycle (next_state=EXEC), 00 otherwise; RCOMP has regwrite=regdst=1.
- opcode=000100 (BEQ) -> aluop=01 in DECODE; BRANCH has pcwritecond=1, pcsource=01; three cycles to return to FETCH.
- opcode=111111 -> DECODE then ILLEGAL with illegal_op=1 for exactly one cycle, then FETCH with no regwrite/memwrite at any point.
- SW in MEMADR, rst_n pulsed low mid-cycle -> state=0 and memwrite=0 asynchronously; after release the sequence is 1,2,3,6 with memwrite=1 only in state 6.
